// File: rtl/obtc_pkg.sv
// Shared types and sizes for the target serializer: FIFO word geometry,
// compact-nBits field widths and the serializer FSM encoding.
package obtc_pkg;

   localparam int WORD_W       = 32;
   localparam int TARGET_W     = 256;
   localparam int TARGET_WORDS = TARGET_W / WORD_W;
   localparam int NBITS_MANT_W = 23;
   localparam int IDX_W        = 3;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TARGET_WORDS - 1);

   typedef enum logic [1:0] {
      TS_IDLE   = 2'd0,
      TS_EXPAND = 2'd1,
      TS_SEND   = 2'd2
   } tser_state_t;

endpackage

// File: rtl/compact_target_expand.sv
// Combinational expansion of a Bitcoin compact difficulty word (nBits)
// into a 256-bit target, with saturation and forced-zero indications.
module compact_target_expand
   import obtc_pkg::*;
(
   input  logic [31:0]         nbits,
   output logic [TARGET_W-1:0] target,
   output logic                overflow,
   output logic                zero
);

   // Mantissa is shifted in a 280-bit field so bits lost above 255 can be detected.
   localparam int WIDE_W = 280;

   logic [7:0]              exp_s;
   logic [NBITS_MANT_W-1:0] mant_s;
   logic [10:0]             shamt_s;
   logic [WIDE_W-1:0]       wide_s;

   // Decode exponent and mantissa, then shift right (small exp) or left (large exp).
   always_comb begin
      exp_s    = nbits[31:24];
      mant_s   = nbits[NBITS_MANT_W-1:0];
      shamt_s  = 11'd0;
      wide_s   = {(WIDE_W-NBITS_MANT_W)'(1'b0), mant_s};
      target   = {TARGET_W{1'b0}};
      overflow = 1'b0;
      zero     = 1'b0;
      if (nbits[23] || (mant_s == {NBITS_MANT_W{1'b0}})) begin
         zero = 1'b1;
      end else if (exp_s <= 8'd3) begin
         shamt_s = {8'd3 - exp_s, 3'b000};
         wide_s  = wide_s >> shamt_s;
         target  = wide_s[TARGET_W-1:0];
      end else if (exp_s >= 8'd35) begin
         overflow = 1'b1;
         target   = {TARGET_W{1'b1}};
      end else begin
         shamt_s = {exp_s - 8'd3, 3'b000};
         wide_s  = wide_s << shamt_s;
         if (|wide_s[WIDE_W-1:TARGET_W]) begin
            overflow = 1'b1;
            target   = {TARGET_W{1'b1}};
         end else begin
            target = wide_s[TARGET_W-1:0];
         end
      end
   end

endmodule

// File: rtl/target_serializer.sv
// Latches a compact nBits word, expands it once, and streams the 256-bit
// target into the target FIFO as eight 32-bit words, least-significant first.
module target_serializer
   import obtc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       nbits,
   input  logic              nbits_valid,
   output logic              nbits_ready,
   input  logic              stop,
   output logic              stop_ack_tgt,
   output logic [WORD_W-1:0] target_fifo_din,
   output logic              target_fifo_we,
   input  logic              target_fifo_full,
   output logic              target_overflow,
   output logic              target_zero,
   output logic              done
);

   tser_state_t         state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [TARGET_W-1:0] target_q, target_d;
   logic [31:0]         nbits_q, nbits_d;
   logic                overflow_q, overflow_d;
   logic                zero_q, zero_d;

   logic [TARGET_W-1:0] exp_target_s;
   logic                exp_overflow_s;
   logic                exp_zero_s;
   logic                we_s;
   logic                done_s;
   logic                idle_s;

   compact_target_expand u_expand (
      .nbits    (nbits_q),
      .target   (exp_target_s),
      .overflow (exp_overflow_s),
      .zero     (exp_zero_s)
   );

   // State, word index, target and per-job flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= TS_IDLE;
         idx_q      <= {IDX_W{1'b0}};
         target_q   <= {TARGET_W{1'b0}};
         nbits_q    <= 32'd0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         target_q   <= target_d;
         nbits_q    <= nbits_d;
         overflow_q <= overflow_d;
         zero_q     <= zero_d;
      end
   end

   // Next-state logic; stop always wins and suppresses the write of its own cycle.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      target_d   = target_q;
      nbits_d    = nbits_q;
      overflow_d = overflow_q;
      zero_d     = zero_q;
      we_s       = 1'b0;
      done_s     = 1'b0;
      idle_s     = 1'b0;
      case (state_q)
         TS_IDLE: begin
            idle_s = 1'b1;
            if (nbits_valid && !stop) begin
               nbits_d    = nbits;
               overflow_d = 1'b0;
               zero_d     = 1'b0;
               state_d    = TS_EXPAND;
            end else begin
               state_d = TS_IDLE;
            end
         end
         TS_EXPAND: begin
            if (stop) begin
               state_d = TS_IDLE;
            end else begin
               target_d   = exp_target_s;
               overflow_d = exp_overflow_s;
               zero_d     = exp_zero_s;
               idx_d      = {IDX_W{1'b0}};
               state_d    = TS_SEND;
            end
         end
         TS_SEND: begin
            if (stop) begin
               state_d = TS_IDLE;
            end else if (!target_fifo_full) begin
               we_s = 1'b1;
               if (idx_q == LAST_IDX) begin
                  done_s  = 1'b1;
                  idx_d   = {IDX_W{1'b0}};
                  state_d = TS_IDLE;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               state_d = TS_SEND;
            end
         end
         default: begin
            state_d = TS_IDLE;
         end
      endcase
   end

   // A reset cycle must never write, even though state is still SEND.
   assign target_fifo_we  = we_s & ~rst;
   assign done            = done_s & ~rst;
   assign target_fifo_din = target_q[idx_q*WORD_W +: WORD_W];
   assign nbits_ready     = idle_s;
   assign stop_ack_tgt    = idle_s;
   assign target_overflow = overflow_q;
   assign target_zero     = zero_q;

endmodule

// File: tb/tb_target_serializer.sv
// Self-checking bench for target_serializer: directed scenarios plus random
// nBits jobs compared against an arithmetic model of compact-target expansion.
module tb_target_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] nbits;
   logic        nbits_valid;
   logic        nbits_ready;
   logic        stop;
   logic        stop_ack_tgt;
   logic [31:0] target_fifo_din;
   logic        target_fifo_we;
   logic        target_fifo_full;
   logic        target_overflow;
   logic        target_zero;
   logic        done;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [31:0] wq[$];
   int done_cnt, done_cyc, acc_cyc, first_cyc, viol;

   target_serializer dut (
      .clk              (clk),
      .rst              (rst),
      .nbits            (nbits),
      .nbits_valid      (nbits_valid),
      .nbits_ready      (nbits_ready),
      .stop             (stop),
      .stop_ack_tgt     (stop_ack_tgt),
      .target_fifo_din  (target_fifo_din),
      .target_fifo_we   (target_fifo_we),
      .target_fifo_full (target_fifo_full),
      .target_overflow  (target_overflow),
      .target_zero      (target_zero),
      .done             (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Observe the FIFO side at the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (nbits_valid && nbits_ready && !stop && !rst) acc_cyc = cyc;
      if (target_fifo_we) begin
         if (wq.size() == 0) first_cyc = cyc;
         wq.push_back(target_fifo_din);
         if (target_fifo_full) viol++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: target = m * 256^(exp-3), computed with wide integer arithmetic.
   function automatic void model(input logic [31:0] nb, output logic [255:0] t,
                                 output logic ov, output logic z);
      int          e;
      logic [511:0] big;
      e   = int'(nb[31:24]);
      big = 512'(nb[22:0]);
      t   = '0;
      ov  = 1'b0;
      z   = 1'b0;
      if (nb[23] || nb[22:0] == 23'd0) begin
         z = 1'b1;
      end else if (e >= 35) begin
         ov = 1'b1;
         t  = '1;
      end else begin
         for (int k = 3; k < e; k++) big = big * 512'd256;
         for (int k = e; k < 3; k++) big = big / 512'd256;
         if (big[511:256] != 256'd0) begin
            ov = 1'b1;
            t  = '1;
         end else begin
            t = big[255:0];
         end
      end
   endfunction

   task automatic clear_obs();
      wq.delete();
      done_cnt  = 0;
      viol      = 0;
      acc_cyc   = -100;
      first_cyc = -100;
      done_cyc  = -100;
   endtask

   task automatic start_job(input logic [31:0] nb);
      nbits       = nb;
      nbits_valid = 1'b1;
      @(posedge clk);
      #1;
      nbits_valid = 1'b0;
      nbits       = $urandom;
   endtask

   task automatic wait_writes(input int n, input string tag);
      int budget = 0;
      while (wq.size() < n && budget < 100) begin
         @(posedge clk);
         #1;
         budget++;
      end
      chk({tag, "_wait"}, 256'(budget < 100), 256'd1);
   endtask

   // Full job: optional FIFO-full stall of stall_len cycles after the first write.
   task automatic run_job(input logic [31:0] nb, input int stall_len, input string tag);
      logic [255:0] t;
      logic         ov, z;
      int           stalled = 0;
      int           budget  = 0;
      model(nb, t, ov, z);
      clear_obs();
      start_job(nb);
      while (done_cnt == 0 && budget < 200) begin
         @(posedge clk);
         #1;
         budget++;
         if (wq.size() >= 1 && stalled < stall_len) begin
            target_fifo_full = 1'b1;
            stalled++;
         end else begin
            target_fifo_full = 1'b0;
         end
      end
      target_fifo_full = 1'b0;
      chk({tag, "_done_cnt"}, 256'(done_cnt), 256'd1);
      chk({tag, "_nwords"}, 256'(wq.size()), 256'd8);
      for (int i = 0; i < 8 && i < wq.size(); i++)
         chk($sformatf("%s_word%0d", tag, i), 256'(wq[i]), 256'(t[32*i +: 32]));
      chk({tag, "_first_lat"}, 256'(first_cyc - acc_cyc), 256'd2);
      chk({tag, "_done_lat"}, 256'(done_cyc - acc_cyc), 256'(9 + stall_len));
      chk({tag, "_we_while_full"}, 256'(viol), 256'd0);
      chk({tag, "_overflow"}, 256'(target_overflow), 256'(ov));
      chk({tag, "_zero"}, 256'(target_zero), 256'(z));
      chk({tag, "_idle_ready"}, 256'(nbits_ready), 256'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, 256'(nbits_ready), 256'd1);
      chk({tag, "_ack"}, 256'(stop_ack_tgt), 256'd1);
      chk({tag, "_we"}, 256'(target_fifo_we), 256'd0);
      chk({tag, "_din"}, 256'(target_fifo_din), 256'd0);
      chk({tag, "_done"}, 256'(done), 256'd0);
      chk({tag, "_ovf"}, 256'(target_overflow), 256'd0);
      chk({tag, "_zero"}, 256'(target_zero), 256'd0);
   endtask

   initial begin
      logic [31:0] rnb;
      rst              = 1'b1;
      nbits            = 32'd0;
      nbits_valid      = 1'b0;
      stop             = 1'b0;
      target_fifo_full = 1'b0;
      clear_obs();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_reset_outputs("reset");

      // nbits offered together with stop must be ignored.
      nbits = 32'h1d00ffff; nbits_valid = 1'b1; stop = 1'b1;
      @(posedge clk);
      #1;
      nbits_valid = 1'b0; stop = 1'b0;
      chk("valid_with_stop_ignored", 256'(nbits_ready), 256'd1);

      run_job(32'h1d00ffff, 0, "t1");
      chk("t1_word6_literal", 256'(wq[6]), 256'h0000ffff0000 & 256'hffffffff);
      run_job(32'h03123456, 0, "t2a");
      chk("t2a_word0_literal", 256'(wq[0]), 256'h00123456);
      run_job(32'h01123456, 0, "t2b");
      chk("t2b_word0_literal", 256'(wq[0]), 256'h00000012);
      run_job(32'h2300ffff, 0, "t3a");
      chk("t3a_ovf_literal", 256'(target_overflow), 256'd1);
      run_job(32'h1d800000, 0, "t3b");
      chk("t3b_zero_literal", 256'(target_zero), 256'd1);
      run_job(32'h1d00ffff, 3, "t4");

      // Stop after word 3 is written; nothing further may be written.
      clear_obs();
      start_job(32'h1d00ffff);
      wait_writes(4, "t5");
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
      chk("t5_ack", 256'(stop_ack_tgt), 256'd1);
      chk("t5_ready", 256'(nbits_ready), 256'd1);
      repeat (4) @(posedge clk);
      #1;
      chk("t5_no_more_we", 256'(wq.size()), 256'd4);
      chk("t5_no_done", 256'(done_cnt), 256'd0);
      run_job(32'h1c7fffff, 0, "t5_restart");

      // Synchronous reset in SEND with idx==5.
      clear_obs();
      start_job(32'h2300ffff);
      wait_writes(5, "t6");
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("t6_no_write_in_reset", 256'(wq.size()), 256'd5);
      chk_reset_outputs("t6");
      run_job(32'h1d00ffff, 0, "t6_fresh");

      for (int j = 0; j < 16; j++) begin
         rnb[31:24] = 8'($urandom_range(0, 40));
         rnb[23]    = ($urandom_range(0, 7) == 0);
         rnb[22:0]  = ($urandom_range(0, 9) == 0) ? 23'd0 : 23'($urandom);
         run_job(rnb, $urandom_range(0, 3), $sformatf("rnd%0d", j));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
